// File: rtl/mdu_iter_pkg.sv
// Shared types for the iterative multiply/divide unit: funct3 op encodings,
// FSM state encodings and the sign/corner-case flags latched at acceptance.
package mdu_iter_pkg;

   localparam int unsigned OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      MDU_MUL    = 3'b000,
      MDU_MULH   = 3'b001,
      MDU_MULHSU = 3'b010,
      MDU_MULHU  = 3'b011,
      MDU_DIV    = 3'b100,
      MDU_DIVU   = 3'b101,
      MDU_REM    = 3'b110,
      MDU_REMU   = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'b00,
      MDU_CALC = 2'b01,
      MDU_DONE = 2'b10
   } state_e;

   typedef struct packed {
      logic sa;    // dividend / multiplicand treated as negative
      logic sb;    // divisor / multiplier treated as negative
      logic div0;  // divide by zero
      logic ovf;   // signed overflow, INT_MIN / -1
   } mdu_flags_t;

   function automatic logic is_div(input op_e o);
      return o inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
   endfunction

   function automatic logic signed_a(input op_e o);
      return o inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
   endfunction

   function automatic logic signed_b(input op_e o);
      return o inside {MDU_MULH, MDU_DIV, MDU_REM};
   endfunction

endpackage

// File: rtl/mdu_neg.sv
// Conditional two's-complement: res_c = neg ? -in_val : in_val.
module mdu_neg #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] in_val,
   input  logic         neg,
   output logic [W-1:0] res_c
);

   assign res_c = neg ? (~in_val + W'(1)) : in_val;

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV M-extension unit: radix-2 shift-add multiply and restoring divide
// sharing one 2*XLEN working register. Optional MDU_EARLY_OUT_EN fast-paths trivial ops.
module mdu_iter
   import mdu_iter_pkg::*;
#(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OP_W-1:0] op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int unsigned      DW       = 2 * XLEN;
   localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   op_e              op_q, op_d;
   mdu_flags_t       flg_q, flg_d;
   logic [DW-1:0]    acc_q, acc_d;
   logic [XLEN-1:0]  dvs_q, dvs_d;
   logic [XLEN-1:0]  result_q, result_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q, in_ready_d;
   logic             busy_q, busy_d;

   // Operand decode and magnitudes at acceptance
   op_e             op_in;
   logic            sa_in, sb_in, b_zero, ovf_in;
   logic [XLEN-1:0] mag_a_c, mag_b_c;

   assign op_in  = op_e'(op);
   assign sa_in  = a[XLEN-1] & signed_a(op_in);
   assign sb_in  = b[XLEN-1] & signed_b(op_in);
   assign b_zero = (b == '0);
   assign ovf_in = (op_in inside {MDU_DIV, MDU_REM}) && (a == INT_MIN) && (b == '1);

   mdu_neg #(.W(XLEN)) u_mag_a (.in_val(a), .neg(sa_in), .res_c(mag_a_c));
   mdu_neg #(.W(XLEN)) u_mag_b (.in_val(b), .neg(sb_in), .res_c(mag_b_c));

`ifdef MDU_EARLY_OUT_EN
   logic            early_c;
   logic [XLEN-1:0] early_res_c;

   always_comb begin
      early_c     = is_div(op_in) ? (b_zero | ovf_in) : ((a == '0) | b_zero);
      early_res_c = '0;
      if (is_div(op_in)) begin
         if (op_in inside {MDU_DIV, MDU_DIVU}) early_res_c = b_zero ? '1 : INT_MIN;
         else                                  early_res_c = b_zero ? a : '0;
      end
   end
`endif

   // One iteration: mul keeps {hi, multiplier}, div keeps {rem, quotient}
   logic [XLEN:0]   mul_sum_c, rem_sh_c, diff_c;
   logic            q_bit_c;
   logic [XLEN-1:0] rem_new_c;
   logic [DW-1:0]   iter_c;

   always_comb begin
      mul_sum_c = {1'b0, acc_q[DW-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
      rem_sh_c  = acc_q[DW-1:XLEN-1];
      diff_c    = rem_sh_c - {1'b0, dvs_q};
      q_bit_c   = ~diff_c[XLEN];
      rem_new_c = q_bit_c ? diff_c[XLEN-1:0] : rem_sh_c[XLEN-1:0];
      if (is_div(op_q)) iter_c = {rem_new_c, acc_q[XLEN-2:0], q_bit_c};
      else              iter_c = {mul_sum_c, acc_q[XLEN-1:1]};
   end

   logic [DW-1:0]   prod_c;
   logic [XLEN-1:0] quo_c, rem_c, fin_c;

   mdu_neg #(.W(DW))   u_neg_prod (.in_val(iter_c), .neg(flg_q.sa ^ flg_q.sb), .res_c(prod_c));
   mdu_neg #(.W(XLEN)) u_neg_quo  (.in_val(iter_c[XLEN-1:0]), .neg(flg_q.sa ^ flg_q.sb), .res_c(quo_c));
   mdu_neg #(.W(XLEN)) u_neg_rem  (.in_val(iter_c[DW-1:XLEN]), .neg(flg_q.sa), .res_c(rem_c));

   // Result select; divide-by-zero remainder already equals a after sign correction
   always_comb begin
      fin_c = '0;
      case (op_q)
         MDU_MUL:                         fin_c = prod_c[XLEN-1:0];
         MDU_MULH, MDU_MULHSU, MDU_MULHU: fin_c = prod_c[DW-1:XLEN];
         MDU_DIV, MDU_DIVU:               fin_c = flg_q.div0 ? '1 : (flg_q.ovf ? INT_MIN : quo_c);
         default:                         fin_c = flg_q.ovf ? '0 : rem_c;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      flg_d    = flg_q;
      acc_d    = acc_q;
      dvs_d    = dvs_q;
      result_d = result_q;
      case (state_q)
         MDU_IDLE: begin
            if (in_valid && in_ready_q) begin
               op_d       = op_in;
               flg_d.sa   = sa_in;
               flg_d.sb   = sb_in;
               flg_d.div0 = is_div(op_in) && b_zero;
               flg_d.ovf  = ovf_in;
               cnt_d      = '0;
               acc_d      = {{XLEN{1'b0}}, mag_a_c};
               dvs_d      = mag_b_c;
               state_d    = MDU_CALC;
`ifdef MDU_EARLY_OUT_EN
               if (early_c) begin
                  state_d  = MDU_DONE;
                  result_d = early_res_c;
               end
`endif
            end
         end
         MDU_CALC: begin
            acc_d = iter_c;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               cnt_d    = '0;
               result_d = fin_c;
               state_d  = MDU_DONE;
            end
         end
         MDU_DONE: if (out_ready) state_d = MDU_IDLE;
         default:  state_d = MDU_IDLE;
      endcase
      if (flush) begin
         state_d  = MDU_IDLE;
         cnt_d    = '0;
         result_d = result_q;
      end
      in_ready_d  = (state_d == MDU_IDLE);
      out_valid_d = (state_d == MDU_DONE);
      busy_d      = (state_d != MDU_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= MDU_IDLE;
         cnt_q       <= '0;
         op_q        <= MDU_MUL;
         flg_q       <= '0;
         acc_q       <= '0;
         dvs_q       <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         flg_q       <= flg_d;
         acc_q       <= acc_d;
         dvs_q       <= dvs_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter (XLEN=32, plus one XLEN=64 multiply check):
// directed ops push expected result and latency, a monitor pops on each handshake.
module tb_mdu_iter;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   // Edges from acceptance edge to the edge that raises out_valid
   localparam int LAT = 32;
`ifdef MDU_EARLY_OUT_EN
   localparam int LAT_EO = 0;
`else
   localparam int LAT_EO = 32;
`endif

   logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
   logic [2:0]  op;
   logic [31:0] a, b, result;

   logic        in_valid64, in_ready64, out_valid64, busy64;
   logic [2:0]  op64;
   logic [63:0] a64, b64, result64;

   mdu_iter #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .busy(busy)
   );

   mdu_iter #(.XLEN(64)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(in_valid64), .in_ready(in_ready64),
      .op(op64), .a(a64), .b(b64), .out_valid(out_valid64), .out_ready(1'b1),
      .result(result64), .busy(busy64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] exp_res_q[$];
   int          exp_lat_q[$];
   string       exp_name_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Cycle counter and acceptance-edge capture
   int cyc = 0;
   int acc_edge = 0;
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst_n && in_valid && in_ready && !flush) acc_edge = cyc;
   end

   // Monitor: latency on first out_valid cycle, result on handshake
   bit lat_done = 1'b0;
   always begin
      @(negedge clk);
      #1;
      if (!rst_n) lat_done = 1'b0;
      else if (out_valid) begin
         if (!lat_done) begin
            lat_done = 1'b1;
            if (exp_lat_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected out_valid: got result %0h, want no output", result);
            end else begin
               check({exp_name_q[0], " latency"}, 64'(cyc - acc_edge), 64'(exp_lat_q[0]));
            end
         end
         if (out_ready) begin
            lat_done = 1'b0;
            if (exp_res_q.size() != 0) begin
               check(exp_name_q[0], 64'(result), 64'(exp_res_q[0]));
               void'(exp_res_q.pop_front());
               void'(exp_lat_q.pop_front());
               void'(exp_name_q.pop_front());
            end
         end
      end
   end

   task automatic issue(input string name, input logic [2:0] o, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [31:0] exp, input int lat, input bit chk);
      int t;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         check({name, " in_ready wait"}, 64'(in_ready), 64'(1));
         return;
      end
      op = o;
      a = aa;
      b = bb;
      in_valid = 1'b1;
      if (chk) begin
         exp_res_q.push_back(exp);
         exp_lat_q.push_back(lat);
         exp_name_q.push_back(name);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_res_q.size() != 0 || !in_ready) && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: got %0d results outstanding, want 0", exp_res_q.size());
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish by time limit, want finish");
      $fatal(1, "watchdog timeout");
   end

   initial begin
      int k;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
      in_valid64 = 1'b0; op64 = '0; a64 = '0; b64 = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst in_ready", 64'(in_ready), 64'(1));
      check("rst out_valid", 64'(out_valid), 64'(0));
      check("rst busy", 64'(busy), 64'(0));
      check("rst result", 64'(result), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors: name, op, a, b, expected, latency
      issue("MULH -1*2",        OP_MULH,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, LAT, 1);
      issue("MUL -1*2",         OP_MUL,    32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, LAT, 1);
      issue("MULHSU min*max",   OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT, 1);
      issue("MULHU min*max",    OP_MULHU,  32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, LAT, 1);
      issue("MULHU max*max",    OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT, 1);
      issue("MULH min*min",     OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, LAT, 1);
      issue("DIV -7/2",         OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, LAT, 1);
      issue("REM -7/2",         OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, LAT, 1);
      issue("DIV 7/-2",         OP_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, LAT, 1);
      issue("REM 7/-2",         OP_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, LAT, 1);
      issue("DIVU 100/7",       OP_DIVU,   32'd100,      32'd7,        32'd14,       LAT, 1);
      issue("REMU 100/7",       OP_REMU,   32'd100,      32'd7,        32'd2,        LAT, 1);
      issue("DIVU 5/0",         OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, LAT_EO, 1);
      issue("REM 5/0",          OP_REM,    32'd5,        32'd0,        32'd5,        LAT_EO, 1);
      issue("REMU 5/0",         OP_REMU,   32'd5,        32'd0,        32'd5,        LAT_EO, 1);
      issue("DIV -7/0",         OP_DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, LAT_EO, 1);
      issue("REM -7/0",         OP_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, LAT_EO, 1);
      issue("DIV ovf",          OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_EO, 1);
      issue("REM ovf",          OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_EO, 1);
      issue("MUL 0*x",          OP_MUL,    32'h00000000, 32'h00012345, 32'h00000000, LAT_EO, 1);
      drain();

      // Back-pressure: result held while out_ready is low
      out_ready = 1'b0;
      issue("hold DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, LAT, 1);
      k = 0;
      while (!out_valid && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("hold out_valid rise", 64'(out_valid), 64'(1));
      repeat (10) begin
         @(negedge clk);
         #1;
         check("hold out_valid", 64'(out_valid), 64'(1));
         check("hold in_ready", 64'(in_ready), 64'(0));
         check("hold result", 64'(result), 64'(14));
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      #1;
      check("release in_ready", 64'(in_ready), 64'(1));
      check("release out_valid", 64'(out_valid), 64'(0));
      op = OP_REMU; a = 32'd100; b = 32'd7; in_valid = 1'b1;
      exp_res_q.push_back(32'd2);
      exp_lat_q.push_back(LAT);
      exp_name_q.push_back("post-hold REMU");
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("post-hold accepted", 64'(busy), 64'(1));
      drain();

      // Flush at CALC counter 15
      issue("flush MUL", OP_MUL, 32'd3, 32'd5, 32'd0, LAT, 0);
      repeat (15) @(negedge clk);
      #1;
      check("flush busy before", 64'(busy), 64'(1));
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush out_valid", 64'(out_valid), 64'(0));
      check("flush in_ready", 64'(in_ready), 64'(1));
      check("flush busy", 64'(busy), 64'(0));
      check("flush result kept", 64'(result), 64'(2));
      repeat (40) @(negedge clk);
      #1;
      check("flush no late valid", 64'(out_valid), 64'(0));

      // Flush with in_valid in IDLE accepts nothing
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      #1;
      check("flush+valid busy", 64'(busy), 64'(0));
      check("flush+valid in_ready", 64'(in_ready), 64'(1));

      // Reset mid-CALC
      issue("reset DIVU", OP_DIVU, 32'd50, 32'd5, 32'd0, LAT, 0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst out_valid", 64'(out_valid), 64'(0));
      check("midrst in_ready", 64'(in_ready), 64'(1));
      check("midrst busy", 64'(busy), 64'(0));
      check("midrst result", 64'(result), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      #1;
      check("postrst out_valid", 64'(out_valid), 64'(0));
      check("postrst in_ready", 64'(in_ready), 64'(1));

      // XLEN=64 multiply
      @(negedge clk);
      check("x64 in_ready", 64'(in_ready64), 64'(1));
      in_valid64 = 1'b1; op64 = OP_MUL; a64 = 64'hFFFFFFFFFFFFFFFF; b64 = 64'd2;
      @(negedge clk);
      in_valid64 = 1'b0;
      k = 0;
      while (!out_valid64 && k < 200) begin
         @(negedge clk);
         k++;
      end
      #1;
      check("x64 latency", 64'(k), 64'(64));
      check("x64 MUL -1*2", result64, 64'hFFFFFFFFFFFFFFFE);

      drain();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
